// File: rtl/cpu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_phase_sequencer
//
// Multi-cycle phase controller for the bbtron datapath. It steps every
// instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK and gates
// the PC, IR, register-bench and data-memory strobes. Input instructions
// stall in WAIT_INPUT until the debounced enter button fires. HLT parks the
// sequencer in HALT until reset.
//
// Optional feature (macro CPU_PHASE_SEQUENCER_STEP_EN):
//   adds step_mode / step_pulse inputs and a STEP_WAIT state (code 7) that
//   holds the machine after every WRITEBACK until step_pulse when step_mode=1.
//   Without the macro, code 7 is unused and recovers to FETCH.
//
// Parameters:
//   MEM_LATENCY  cycles spent in MEMORY per load/store (1..15)
//   CNT_WIDTH    width of the retired-instruction counter
//
// Ports:
//   clock           system clock, rising edge
//   n_reset         asynchronous active-low reset
//   cu_hlt          decoded instruction is HLT
//   cu_inSignal     decoded instruction reads the switches
//   cu_readEnable   decoded instruction reads data memory
//   cu_writeEnable  decoded instruction writes data memory
//   cu_writeReg     decoded instruction writes the register bench
//   enter_pulse     one-cycle debounced enter pulse
//   step_mode       (optional) hold after each instruction
//   step_pulse      (optional) release from STEP_WAIT
//   pc_en           PC load enable (WRITEBACK)
//   ir_en           IR load enable (FETCH)
//   reg_we          register bench write strobe (WRITEBACK)
//   mem_re          data memory read strobe (every MEMORY cycle)
//   mem_we          data memory write strobe (first MEMORY cycle)
//   phase           current state code
//   waiting         stalled for the enter button (or step pulse)
//   halted          in HALT
//   instr_count     retired-instruction counter, wraps
// ---------------------------------------------------------------------------
module cpu_phase_sequencer #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 n_reset,
  input  logic                 cu_hlt,
  input  logic                 cu_inSignal,
  input  logic                 cu_readEnable,
  input  logic                 cu_writeEnable,
  input  logic                 cu_writeReg,
  input  logic                 enter_pulse,
`ifdef CPU_PHASE_SEQUENCER_STEP_EN
  input  logic                 step_mode,
  input  logic                 step_pulse,
`endif
  output logic                 pc_en,
  output logic                 ir_en,
  output logic                 reg_we,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [2:0]           phase,
  output logic                 waiting,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    DECODE     = 3'd1,
    EXECUTE    = 3'd2,
    MEMORY     = 3'd3,
    WRITEBACK  = 3'd4,
    WAIT_INPUT = 3'd5,
    HALT       = 3'd6
`ifdef CPU_PHASE_SEQUENCER_STEP_EN
    , STEP_WAIT = 3'd7
`endif
  } state_t;

  // Counter value loaded on entry to MEMORY; it also marks the first MEMORY
  // cycle, which is the only one allowed to strobe a write.
  localparam logic [3:0] MEM_LOAD = 4'(MEM_LATENCY - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] wait_cnt;
  logic       mem_access;

  assign mem_access = cu_readEnable | cu_writeEnable;

  // State register plus the memory-wait counter and the retired-instruction
  // counter. The wait counter only moves when entering or inside MEMORY, so
  // it stays frozen in HALT and while stalled.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= FETCH;
      wait_cnt    <= 4'd0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXECUTE && mem_access) begin
        wait_cnt <= MEM_LOAD;
      end else if (state_q == MEMORY && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state_q == WRITEBACK) begin
        instr_count <= instr_count + CNT_WIDTH'(1);
      end
    end
  end

  // Next-state logic. HLT wins over an input instruction in DECODE;
  // enter_pulse is only looked at while in WAIT_INPUT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:      state_d = DECODE;
      DECODE: begin
        if (cu_hlt) begin
          state_d = HALT;
        end else if (cu_inSignal) begin
          state_d = WAIT_INPUT;
        end else begin
          state_d = EXECUTE;
        end
      end
      WAIT_INPUT: if (enter_pulse) state_d = EXECUTE;
      EXECUTE:    state_d = mem_access ? MEMORY : WRITEBACK;
      MEMORY:     if (wait_cnt == 4'd0) state_d = WRITEBACK;
`ifdef CPU_PHASE_SEQUENCER_STEP_EN
      WRITEBACK:  state_d = step_mode ? STEP_WAIT : FETCH;
      STEP_WAIT:  if (step_pulse) state_d = FETCH;
`else
      WRITEBACK:  state_d = FETCH;
`endif
      HALT:       state_d = HALT;
      default:    state_d = FETCH;
    endcase
  end

  // Output decode. Strobes are forced low while reset is held so the
  // datapath sees nothing even though the state already reads FETCH.
  always_comb begin
    pc_en   = 1'b0;
    ir_en   = 1'b0;
    reg_we  = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    waiting = 1'b0;
    halted  = 1'b0;
    if (n_reset) begin
      case (state_q)
        FETCH:      ir_en   = 1'b1;
        MEMORY: begin
          mem_re = cu_readEnable;
          mem_we = cu_writeEnable && (wait_cnt == MEM_LOAD);
        end
        WRITEBACK: begin
          reg_we = cu_writeReg;
          pc_en  = 1'b1;
        end
        WAIT_INPUT: waiting = 1'b1;
`ifdef CPU_PHASE_SEQUENCER_STEP_EN
        STEP_WAIT:  waiting = 1'b1;
`endif
        HALT:       halted  = 1'b1;
        default: begin
        end
      endcase
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_phase_sequencer
//
// Self-checking bench for cpu_phase_sequencer. A reference model turns each
// instruction's decode flags into the list of phases and strobes it should
// produce, cycle by cycle; directed and random instructions are walked
// against that list. Dedicated tasks cover reset, HALT, counter wraparound
// and asynchronous reset in the middle of a memory access.
// ---------------------------------------------------------------------------
module tb_cpu_phase_sequencer;

  localparam int MEM_LAT = 3;
  localparam int CW      = 8;
  localparam int CNT_MOD = 1 << CW;

  localparam logic [2:0] P_FETCH = 3'd0;
  localparam logic [2:0] P_DEC   = 3'd1;
  localparam logic [2:0] P_EXE   = 3'd2;
  localparam logic [2:0] P_MEM   = 3'd3;
  localparam logic [2:0] P_WB    = 3'd4;
  localparam logic [2:0] P_WAIT  = 3'd5;
  localparam logic [2:0] P_HALT  = 3'd6;

  // Strobe vector order: {pc_en, ir_en, reg_we, mem_re, mem_we, waiting, halted}
  typedef struct packed {
    logic [2:0] ph;
    logic [6:0] st;
  } exp_t;

  logic          clock;
  logic          n_reset;
  logic          cu_hlt;
  logic          cu_inSignal;
  logic          cu_readEnable;
  logic          cu_writeEnable;
  logic          cu_writeReg;
  logic          enter_pulse;
  logic          pc_en;
  logic          ir_en;
  logic          reg_we;
  logic          mem_re;
  logic          mem_we;
  logic [2:0]    phase;
  logic          waiting;
  logic          halted;
  logic [CW-1:0] instr_count;

  int   checks;
  int   passed;
  int   exp_count;
  exp_t sched[$];

  cpu_phase_sequencer #(
    .MEM_LATENCY(MEM_LAT),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock         (clock),
    .n_reset       (n_reset),
    .cu_hlt        (cu_hlt),
    .cu_inSignal   (cu_inSignal),
    .cu_readEnable (cu_readEnable),
    .cu_writeEnable(cu_writeEnable),
    .cu_writeReg   (cu_writeReg),
    .enter_pulse   (enter_pulse),
    .pc_en         (pc_en),
    .ir_en         (ir_en),
    .reg_we        (reg_we),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .phase         (phase),
    .waiting       (waiting),
    .halted        (halted),
    .instr_count   (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] strobes();
    return {pc_en, ir_en, reg_we, mem_re, mem_we, waiting, halted};
  endfunction

  // Reference model: expected per-cycle phase/strobes of one instruction,
  // starting with its FETCH cycle. stall = number of WAIT_INPUT cycles.
  task automatic build_schedule(input logic hlt, input logic in_sig,
                                input logic re, input logic we,
                                input logic wr, input int stall);
    sched.delete();
    sched.push_back('{P_FETCH, 7'b0100000});
    sched.push_back('{P_DEC, 7'b0000000});
    if (hlt) begin
      sched.push_back('{P_HALT, 7'b0000001});
    end else begin
      if (in_sig) begin
        for (int i = 0; i < stall; i++) sched.push_back('{P_WAIT, 7'b0000010});
      end
      sched.push_back('{P_EXE, 7'b0000000});
      if (re || we) begin
        for (int i = 0; i < MEM_LAT; i++)
          sched.push_back('{P_MEM, {3'b000, re, we && (i == 0), 2'b00}});
      end
      sched.push_back('{P_WB, {1'b1, 1'b0, wr, 4'b0000}});
    end
  endtask

  task automatic set_flags(input logic hlt, input logic in_sig, input logic re,
                           input logic we, input logic wr);
    cu_hlt         = hlt;
    cu_inSignal    = in_sig;
    cu_readEnable  = re;
    cu_writeEnable = we;
    cu_writeReg    = wr;
  endtask

  // Holds reset for two edges, then releases it right after an edge so the
  // following cycle is the first FETCH.
  task automatic test_reset();
    n_reset = 1'b0;
    set_flags(0, 0, 0, 0, 0);
    enter_pulse = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (phase !== P_FETCH || strobes() !== 7'b0 || instr_count !== '0) begin
      $display("[TB] FAIL reset_hold phase=%0d strobes=%b count=%0d expected phase=0 strobes=0 count=0",
               phase, strobes(), instr_count);
    end else passed++;
    n_reset = 1'b1;
    #1;
    checks++;
    if (phase !== P_FETCH || strobes() !== 7'b0100000) begin
      $display("[TB] FAIL reset_release phase=%0d strobes=%b expected phase=0 strobes=0100000",
               phase, strobes());
    end else passed++;
    exp_count = 0;
  endtask

  // ALU, load, store and input instructions. A stray enter pulse is driven
  // in every DECODE cycle; the input instruction stalls 10 cycles.
  task automatic test_directed();
    logic [4:0] flags [4];
    int         stall [4];
    flags[0] = 5'b00001; stall[0] = 0;
    flags[1] = 5'b00101; stall[1] = 0;
    flags[2] = 5'b00010; stall[2] = 0;
    flags[3] = 5'b01001; stall[3] = 10;
    for (int n = 0; n < 4; n++) begin
      set_flags(flags[n][4], flags[n][3], flags[n][2], flags[n][1], flags[n][0]);
      build_schedule(flags[n][4], flags[n][3], flags[n][2], flags[n][1], flags[n][0], stall[n]);
      for (int k = 0; k < sched.size(); k++) begin
        checks++;
        if (phase !== sched[k].ph || strobes() !== sched[k].st || instr_count !== exp_count[CW-1:0]) begin
          $display("[TB] FAIL directed%0d cycle %0d: phase=%0d strobes=%b count=%0d expected phase=%0d strobes=%b count=%0d",
                   n, k, phase, strobes(), instr_count, sched[k].ph, sched[k].st, exp_count);
        end else passed++;
        if (sched[k].ph == P_WB) exp_count = (exp_count + 1) % CNT_MOD;
        if (sched[k].ph == P_WAIT) enter_pulse = (k + 1 < sched.size()) && (sched[k + 1].ph != P_WAIT);
        else enter_pulse = (sched[k].ph == P_DEC);
        @(posedge clock);
        #1;
      end
      enter_pulse = 1'b0;
    end
    checks++;
    if (phase !== P_FETCH || instr_count !== exp_count[CW-1:0]) begin
      $display("[TB] FAIL directed_end phase=%0d count=%0d expected phase=0 count=%0d",
               phase, instr_count, exp_count);
    end else passed++;
  endtask

  // Random non-HLT instructions with random stalls and random enter pulses
  // outside WAIT_INPUT, which must be ignored.
  task automatic test_random(input int count);
    logic in_sig, re, we, wr;
    int   stall;
    for (int n = 0; n < count; n++) begin
      in_sig = ($urandom_range(0, 2) == 0);
      re     = 1'($urandom);
      we     = 1'($urandom);
      wr     = 1'($urandom);
      stall  = $urandom_range(1, 6);
      set_flags(1'b0, in_sig, re, we, wr);
      build_schedule(1'b0, in_sig, re, we, wr, stall);
      for (int k = 0; k < sched.size(); k++) begin
        checks++;
        if (phase !== sched[k].ph || strobes() !== sched[k].st || instr_count !== exp_count[CW-1:0]) begin
          $display("[TB] FAIL random%0d cycle %0d: phase=%0d strobes=%b count=%0d expected phase=%0d strobes=%b count=%0d",
                   n, k, phase, strobes(), instr_count, sched[k].ph, sched[k].st, exp_count);
        end else passed++;
        if (sched[k].ph == P_WB) exp_count = (exp_count + 1) % CNT_MOD;
        if (sched[k].ph == P_WAIT) enter_pulse = (k + 1 < sched.size()) && (sched[k + 1].ph != P_WAIT);
        else enter_pulse = 1'($urandom);
        @(posedge clock);
        #1;
      end
      enter_pulse = 1'b0;
    end
  endtask

  // HLT together with an input flag must halt; HALT holds for 50 cycles
  // regardless of enter pulses, and only reset leaves it.
  task automatic test_halt();
    set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    build_schedule(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 52; k++) begin
      checks++;
      if (phase !== sched[(k < 2) ? k : 2].ph || strobes() !== sched[(k < 2) ? k : 2].st ||
          instr_count !== exp_count[CW-1:0]) begin
        $display("[TB] FAIL halt cycle %0d: phase=%0d strobes=%b count=%0d expected phase=%0d strobes=%b count=%0d",
                 k, phase, strobes(), instr_count, sched[(k < 2) ? k : 2].ph,
                 sched[(k < 2) ? k : 2].st, exp_count);
      end else passed++;
      enter_pulse = 1'($urandom);
      @(posedge clock);
      #1;
    end
    enter_pulse = 1'b0;
    n_reset = 1'b0;
    #1;
    checks++;
    if (phase !== P_FETCH || strobes() !== 7'b0 || instr_count !== '0) begin
      $display("[TB] FAIL halt_reset phase=%0d strobes=%b count=%0d expected phase=0 strobes=0 count=0",
               phase, strobes(), instr_count);
    end else passed++;
    set_flags(0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    n_reset = 1'b1;
    #1;
    exp_count = 0;
    checks++;
    if (phase !== P_FETCH || strobes() !== 7'b0100000) begin
      $display("[TB] FAIL halt_release phase=%0d strobes=%b expected phase=0 strobes=0100000",
               phase, strobes());
    end else passed++;
  endtask

  // ALU instructions back to back until the counter reaches its maximum,
  // then two more: it must wrap to 0 and keep counting.
  task automatic test_wrap();
    int extra;
    set_flags(0, 0, 0, 0, 1);
    extra = 2;
    while (extra > 0) begin
      repeat (4) begin
        @(posedge clock);
        #1;
      end
      if (exp_count == CNT_MOD - 1) extra--;
      else if (extra < 2) extra--;
      exp_count = (exp_count + 1) % CNT_MOD;
      checks++;
      if (phase !== P_FETCH || instr_count !== exp_count[CW-1:0]) begin
        $display("[TB] FAIL wrap phase=%0d count=%0d expected phase=0 count=%0d",
                 phase, instr_count, exp_count);
      end else passed++;
    end
  endtask

  // Load instruction interrupted by reset partway through a MEMORY cycle;
  // strobes and counter must clear before the next clock edge.
  task automatic test_reset_mid_memory();
    set_flags(0, 0, 1, 0, 1);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checks++;
    if (phase !== P_MEM || mem_re !== 1'b1) begin
      $display("[TB] FAIL mem_entry phase=%0d mem_re=%b expected phase=3 mem_re=1", phase, mem_re);
    end else passed++;
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if (phase !== P_FETCH || strobes() !== 7'b0 || instr_count !== '0) begin
      $display("[TB] FAIL mem_async_reset phase=%0d strobes=%b count=%0d expected phase=0 strobes=0 count=0",
               phase, strobes(), instr_count);
    end else passed++;
    @(posedge clock);
    #1;
    n_reset = 1'b1;
    #1;
    exp_count = 0;
    checks++;
    if (phase !== P_FETCH || strobes() !== 7'b0100000) begin
      $display("[TB] FAIL mem_release phase=%0d strobes=%b expected phase=0 strobes=0100000",
               phase, strobes());
    end else passed++;
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    exp_count = 0;
    test_reset();
    test_directed();
    test_random(40);
    test_halt();
    test_wrap();
    test_reset_mid_memory();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
